// File: rtl/read_module.sv
// Fetches a run of 32-bit words from the input BRAM region and streams them out
// as pixels, most-significant pixel first, over a valid/ready handshake.
module read_module #(
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  INPUT_ADDR     = '0,
  parameter int unsigned            PIXEL_SIZE     = 8,
  parameter int unsigned            PIXEL_PER_WORD = 4,
  parameter int unsigned            BRAM_LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           num_words,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [PIXEL_SIZE-1:0] pixel,
  output logic                  pixel_valid,
  input  logic                  pixel_ready
);

  localparam int unsigned IDX_W  = (PIXEL_PER_WORD > 1) ? $clog2(PIXEL_PER_WORD) : 1;
  localparam int unsigned WAIT_W = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(BRAM_LATENCY - 1);
  localparam logic [IDX_W-1:0]  TOP_IDX   = IDX_W'(PIXEL_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_STREAM,
    S_FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           words_q, words_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;

  logic [PIXEL_SIZE-1:0] pix_arr [PIXEL_PER_WORD];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= INPUT_ADDR;
      words_q <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
    end
  end

  // NOTE: every signal assigned below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    word_d  = word_q;
    idx_d   = idx_q;
    wait_d  = wait_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words != 16'd0) begin
            words_d = num_words;
            addr_d  = INPUT_ADDR;
            state_d = S_REQUEST;
          end else begin
            state_d = S_FINISH;
          end
        end
      end

      S_REQUEST: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (wait_q == LAST_WAIT) begin
          word_d  = bram_rdata;
          idx_d   = TOP_IDX;
          state_d = S_STREAM;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_STREAM: begin
        if (pixel_ready) begin
          if (idx_q == '0) begin
            words_d = words_q - 16'd1;
            if (words_q == 16'd1) begin
              state_d = S_FINISH;
            end else begin
              // Byte addressing: one 32-bit word is 4 bytes; wrap is silent.
              addr_d  = addr_q + ADDR_WIDTH'(4);
              state_d = S_REQUEST;
            end
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Slot i holds the pixel at bit offset i*PIXEL_SIZE; the top slot streams first.
  always_comb begin
    for (int i = 0; i < int'(PIXEL_PER_WORD); i++) begin
      pix_arr[i] = word_q[i*PIXEL_SIZE +: PIXEL_SIZE];
    end
  end

  assign bram_en     = (state_q == S_REQUEST);
  assign bram_addr   = addr_q;
  assign pixel_valid = (state_q == S_STREAM);
  assign pixel       = pixel_valid ? pix_arr[idx_q] : '0;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);

endmodule

// File: tb/tb_read_module.sv
// Directed bench for read_module: an expected per-cycle timeline is built from
// the transfer rules, then one compare process checks the DUT against it.
module tb_read_module;

  localparam int L    = 2;
  localparam int P    = 4;
  localparam int TMAX = 64;
  localparam logic [31:0] IADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num_words;
  logic        busy, done, bram_en, pixel_valid, pixel_ready;
  logic [31:0] bram_addr, bram_rdata;
  logic [7:0]  pixel;

  read_module #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .INPUT_ADDR(IADDR),
    .PIXEL_SIZE(8), .PIXEL_PER_WORD(P), .BRAM_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_rdata(bram_rdata), .pixel(pixel), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready)
  );

  always #5 clk = ~clk;

  // BRAM model: data for an enable in cycle t is visible in cycle t+L only.
  logic [31:0] mem [8];
  logic [31:0] pipe_a [L];
  logic        pipe_v [L];
  always @(posedge clk) begin
    pipe_v[0] <= bram_en;
    pipe_a[0] <= bram_addr;
    for (int i = 1; i < L; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
  end
  assign bram_rdata = pipe_v[L-1] ? mem[pipe_a[L-1][4:2]] : 32'hDEAD_BEEF;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected timeline, indexed by cycle relative to the start cycle (0).
  bit          exp_en    [TMAX];
  logic [31:0] exp_addr  [TMAX];
  bit          exp_valid [TMAX];
  logic [7:0]  exp_pix   [TMAX];
  bit          exp_done  [TMAX];
  bit          exp_busy  [TMAX];
  bit          ready_arr [TMAX];
  bit          chk_rst   [TMAX];
  int          done_rel;
  int          tl_len;

  task automatic build_timeline(input int n, input int sw, input int sp, input int sl,
                                input int reset_rel);
    int t;
    logic [31:0] w;
    int stall;
    for (int c = 0; c < TMAX; c++) begin
      exp_en[c] = 0; exp_addr[c] = '0; exp_valid[c] = 0; exp_pix[c] = '0;
      exp_done[c] = 0; exp_busy[c] = 0; chk_rst[c] = 0; ready_arr[c] = c[0];
    end
    t = 1;
    for (int k = 0; k < n; k++) begin
      exp_en[t]   = 1;
      exp_addr[t] = IADDR + 32'(4 * k);
      t += 1 + L;
      w = mem[k % 8];
      for (int p = 0; p < P; p++) begin
        stall = (k == sw && p == sp) ? sl : 0;
        for (int s = 0; s <= stall; s++) begin
          exp_valid[t] = 1;
          exp_pix[t]   = 8'(w >> ((P - 1 - p) * 8));
          ready_arr[t] = (s == stall);
          t++;
        end
      end
    end
    exp_done[t] = 1;
    for (int c = 1; c <= t; c++) exp_busy[c] = 1;
    done_rel = t;
    tl_len   = t + 5;
    if (reset_rel >= 0) begin
      for (int c = reset_rel + 1; c < TMAX; c++) begin
        exp_en[c] = 0; exp_valid[c] = 0; exp_done[c] = 0; exp_busy[c] = 0;
      end
      chk_rst[reset_rel + 1] = 1;
      done_rel = -1;
      tl_len   = reset_rel + 6;
    end
  endtask

  int          rel = 0;
  bit          active = 0;
  logic [7:0]  got [$];

  // Single compare process, sampling mid-cycle away from the rising edge.
  always @(negedge clk) begin
    if (active) begin
      check($sformatf("valid@%0d", rel), 32'(pixel_valid), 32'(exp_valid[rel]));
      check($sformatf("en@%0d", rel),    32'(bram_en),     32'(exp_en[rel]));
      check($sformatf("done@%0d", rel),  32'(done),        32'(exp_done[rel]));
      check($sformatf("busy@%0d", rel),  32'(busy),        32'(exp_busy[rel]));
      if (exp_valid[rel]) check($sformatf("pixel@%0d", rel), 32'(pixel), 32'(exp_pix[rel]));
      if (exp_en[rel])    check($sformatf("addr@%0d", rel), bram_addr, exp_addr[rel]);
      if (chk_rst[rel]) begin
        check($sformatf("rst_addr@%0d", rel),  bram_addr, IADDR);
        check($sformatf("rst_pixel@%0d", rel), 32'(pixel), 32'h0);
      end
      if (pixel_valid && pixel_ready) got.push_back(pixel);
    end
  end

  task automatic run_test(input int n, input int sw, input int sp, input int sl,
                          input int restart_rel, input int reset_rel);
    build_timeline(n, sw, sp, sl, reset_rel);
    got.delete();
    @(posedge clk); #1;
    rel = 0; start = 1'b1; num_words = 16'(n); pixel_ready = 1'b0; active = 1;
    for (int c = 1; c < tl_len; c++) begin
      @(posedge clk); #1;
      rel         = c;
      start       = (c == restart_rel);
      reset       = (c == reset_rel);
      num_words   = 16'hFFFF;
      pixel_ready = ready_arr[c];
    end
    @(posedge clk); #1;
    active = 0; start = 1'b0; reset = 1'b0; pixel_ready = 1'b0;
  endtask

  initial begin
    mem[0] = 32'hAABBCCDD; mem[1] = 32'h11223344; mem[2] = 32'h55667788;
    mem[3] = 32'h99A0B1C2; mem[4] = 32'h0F1E2D3C; mem[5] = 32'h4B5A6978;
    mem[6] = 32'h8796A5B4; mem[7] = 32'hC3D2E1F0;
    reset = 1'b1; start = 1'b0; num_words = '0; pixel_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy",  32'(busy), 32'h0);
    check("reset_done",  32'(done), 32'h0);
    check("reset_en",    32'(bram_en), 32'h0);
    check("reset_valid", 32'(pixel_valid), 32'h0);
    check("reset_pixel", 32'(pixel), 32'h0);
    check("reset_addr",  bram_addr, IADDR);

    // One word, ready held high.
    run_test(1, -1, -1, 0, -1, -1);
    check("t1_model_done_rel", 32'(done_rel), 32'd8);
    check("t1_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      check("t1_px0", 32'(got[0]), 32'hAA);
      check("t1_px1", 32'(got[1]), 32'hBB);
      check("t1_px2", 32'(got[2]), 32'hCC);
      check("t1_px3", 32'(got[3]), 32'hDD);
    end

    // Three words, requests every 7 cycles.
    run_test(3, -1, -1, 0, -1, -1);
    check("t2_model_done_rel", 32'(done_rel), 32'd22);
    check("t2_model_en8",  32'(exp_en[8]),  32'd1);
    check("t2_model_en15", 32'(exp_en[15]), 32'd1);
    check("t2_count", 32'(got.size()), 32'd12);
    if (got.size() == 12) check("t2_px11", 32'(got[11]), 32'h88);

    // Backpressure: ready low for 3 cycles on the second pixel.
    run_test(2, 0, 1, 3, -1, -1);
    check("t3_model_done_rel", 32'(done_rel), 32'd18);
    check("t3_model_hold_pix", 32'(exp_pix[6]), 32'hBB);
    check("t3_count", 32'(got.size()), 32'd8);
    if (got.size() == 8) check("t3_px1", 32'(got[1]), 32'hBB);

    // Zero words: done in cycle 1, no BRAM access, no pixels.
    run_test(0, -1, -1, 0, -1, -1);
    check("t4_model_done_rel", 32'(done_rel), 32'd1);
    check("t4_count", 32'(got.size()), 32'd0);

    // Start re-pulsed while busy is ignored.
    run_test(2, -1, -1, 0, 5, -1);
    check("t5_count", 32'(got.size()), 32'd8);

    // Start coinciding with done is ignored.
    run_test(1, -1, -1, 0, 8, -1);
    check("t6_count", 32'(got.size()), 32'd4);

    // Reset in cycle 5 aborts the transfer silently.
    run_test(2, -1, -1, 0, -1, 5);

    // Fresh start after the abort reads from the base address again.
    run_test(1, -1, -1, 0, -1, -1);
    check("t8_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) check("t8_px0", 32'(got[0]), 32'hAA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
